// File: rtl/arit_mpy_pkg.sv
// Shared constants for the hardware multiplier: mode encodings, FSM state
// codes and the byte-operand width.
package arit_pkg;

  localparam logic [1:0] MODE_MPY  = 2'b00;
  localparam logic [1:0] MODE_MPYS = 2'b01;
  localparam logic [1:0] MODE_MAC  = 2'b10;
  localparam logic [1:0] MODE_MACS = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;

  localparam int BYTE_W = 8;

  // Bit 0 of MODE selects signed operation.
  function automatic logic mode_signed(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/arit_mpy_if.sv
// Peripheral-side bus of the multiplier: request/operand inputs and
// result/status outputs.
interface arit_mpy_if #(parameter int SIZE = 16);

  logic              START;
  logic [1:0]        MODE;
  logic              BW;
  logic              CLR_ACC;
  logic [SIZE-1:0]   OP1;
  logic [SIZE-1:0]   OP2;
  logic [2*SIZE-1:0] RES;
  logic              SUMEXT;
  logic              V;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, MODE, BW, CLR_ACC, OP1, OP2,
    input  RES, SUMEXT, V, BUSY, DONE
  );

  modport slave (
    input  START, MODE, BW, CLR_ACC, OP1, OP2,
    output RES, SUMEXT, V, BUSY, DONE
  );

endinterface

// File: rtl/arit_mpy_step.sv
// One radix-2 shift-add iteration: adds the (pre-shifted) multiplicand to
// the partial product when the current multiplier bit is set.
module arit_mpy_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] pp_in,
  input  logic [W-1:0] mcand,
  input  logic         mbit,
  output logic [W-1:0] pp_out
);

  assign pp_out = mbit ? (pp_in + mcand) : pp_in;

endmodule

// File: rtl/arit_mpy.sv
// Multi-cycle multiply / multiply-accumulate unit (MPY, MPYS, MAC, MACS).
// Define ARIT_MPY_SAT_EN to saturate MACS results on signed overflow.
module arit_mpy
  import arit_pkg::*;
#(
  parameter int SIZE = 16,
  parameter int CW   = 5
) (
  input logic      clk,
  input logic      rst,
  arit_mpy_if.slave bus
);

  localparam int W = 2 * SIZE;

  logic [1:0]      state;
  logic [1:0]      mode_q;
  logic            neg_q;
  logic            acc_ph;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    mcand;
  logic [SIZE-1:0] mplier;
  logic [W-1:0]    pp;
  logic [W-1:0]    pp_next;
  logic [W-1:0]    prod_q;
  logic [W-1:0]    res_q;
  logic            sumext_q;
  logic            v_q;
  logic            busy_q;
  logic            done_q;

  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [CW-1:0]   n_load;
  logic [W-1:0]    prod_c;
  logic [W:0]      sum;
  logic            ovf;
  logic [W-1:0]    acc_val;
  logic            sumext_n;
  logic            v_n;

  // Operands are extended from bit N-1 and reduced to magnitudes so the
  // shift-add core only ever multiplies unsigned values.
  always_comb begin
    a_neg = mode_signed(bus.MODE) & (bus.BW ? bus.OP1[BYTE_W-1] : bus.OP1[SIZE-1]);
    b_neg = mode_signed(bus.MODE) & (bus.BW ? bus.OP2[BYTE_W-1] : bus.OP2[SIZE-1]);
    a_ext = bus.OP1;
    b_ext = bus.OP2;
    if (bus.BW) begin
      a_ext = {{(SIZE-BYTE_W){a_neg}}, bus.OP1[BYTE_W-1:0]};
      b_ext = {{(SIZE-BYTE_W){b_neg}}, bus.OP2[BYTE_W-1:0]};
    end
    a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
    b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
    n_load = bus.BW ? CW'(BYTE_W) : CW'(SIZE);
  end

  arit_mpy_step #(.W(W)) u_step (
    .pp_in  (pp),
    .mcand  (mcand),
    .mbit   (mplier[0]),
    .pp_out (pp_next)
  );

  assign prod_c = neg_q ? (~pp + 1'b1) : pp;
  assign sum    = {1'b0, res_q} + {1'b0, prod_q};
  assign ovf    = (res_q[W-1] == prod_q[W-1]) && (sum[W-1] != res_q[W-1]);

  // Result and flags committed at the end of ACC, selected by captured mode.
  always_comb begin
    acc_val  = prod_q;
    sumext_n = 1'b0;
    v_n      = 1'b0;
    case (mode_q)
      MODE_MPY: begin
        acc_val = prod_q;
      end
      MODE_MPYS: begin
        acc_val  = prod_q;
        sumext_n = prod_q[W-1];
      end
      MODE_MAC: begin
        acc_val  = sum[W-1:0];
        sumext_n = sum[W];
      end
      default: begin
        acc_val = sum[W-1:0];
        v_n     = ovf;
`ifdef ARIT_MPY_SAT_EN
        if (ovf)
          acc_val = prod_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        sumext_n = acc_val[W-1];
      end
    endcase
  end

  // Control FSM: IDLE captures, MUL iterates N times, ACC forms the signed
  // product in its first cycle and commits the result in its second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_MPY;
      neg_q    <= 1'b0;
      acc_ph   <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      pp       <= '0;
      prod_q   <= '0;
      res_q    <= '0;
      sumext_q <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.CLR_ACC)
            res_q <= '0;
          if (bus.START) begin
            mode_q <= bus.MODE;
            neg_q  <= a_neg ^ b_neg;
            mcand  <= {{SIZE{1'b0}}, a_mag};
            mplier <= b_mag;
            pp     <= '0;
            cnt    <= n_load;
            acc_ph <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          pp     <= pp_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= ST_ACC;
        end
        ST_ACC: begin
          if (!acc_ph) begin
            prod_q <= prod_c;
            acc_ph <= 1'b1;
          end else begin
            res_q    <= acc_val;
            sumext_q <= sumext_n;
            v_q      <= v_n;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RES    = res_q;
  assign bus.SUMEXT = sumext_q;
  assign bus.V      = v_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_arit_mpy.sv
// Directed self-checking bench for arit_mpy (SIZE=16), with expectations
// adjusted when ARIT_MPY_SAT_EN is defined.
module tb_arit_mpy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   lat;
  int   busy_cnt;
  int   done_cnt;

  arit_mpy_if #(.SIZE(16)) bus_if ();

  arit_mpy #(.SIZE(16), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs while busy, and wait for DONE.
  task automatic applyStimulus(input logic [1:0] mode, input logic bw, input logic clr,
                               input logic [15:0] op1, input logic [15:0] op2,
                               output int latency, output int busy_samples);
    @(negedge clk);
    bus_if.MODE    = mode;
    bus_if.BW      = bw;
    bus_if.CLR_ACC = clr;
    bus_if.OP1     = op1;
    bus_if.OP2     = op2;
    bus_if.START   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.START   = 1'b0;
    bus_if.CLR_ACC = 1'b0;
    bus_if.MODE    = ~mode;
    bus_if.BW      = ~bw;
    bus_if.OP1     = ~op1;
    bus_if.OP2     = op2 ^ 16'h5A5A;
    checkOutput("busy_after_start", {63'd0, bus_if.BUSY}, 64'd1);
    latency      = 0;
    busy_samples = 0;
    while (!bus_if.DONE && latency < 100) begin
      @(posedge clk);
      #1;
      latency++;
      if (bus_if.BUSY) busy_samples++;
    end
    checkOutput("done_seen", {63'd0, bus_if.DONE}, 64'd1);
    checkOutput("busy_at_done", {63'd0, bus_if.BUSY}, 64'd0);
  endtask

  initial begin
    bus_if.START   = 1'b0;
    bus_if.MODE    = 2'b00;
    bus_if.BW      = 1'b0;
    bus_if.CLR_ACC = 1'b0;
    bus_if.OP1     = '0;
    bus_if.OP2     = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_res",    {32'd0, bus_if.RES}, 64'd0);
    checkOutput("rst_busy",   {63'd0, bus_if.BUSY}, 64'd0);
    checkOutput("rst_done",   {63'd0, bus_if.DONE}, 64'd0);
    checkOutput("rst_v",      {63'd0, bus_if.V}, 64'd0);
    checkOutput("rst_sumext", {63'd0, bus_if.SUMEXT}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b00, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, lat, busy_cnt);
    checkOutput("mpy_res",      {32'd0, bus_if.RES}, 64'hFFFE0001);
    checkOutput("mpy_sumext",   {63'd0, bus_if.SUMEXT}, 64'd0);
    checkOutput("mpy_v",        {63'd0, bus_if.V}, 64'd0);
    checkOutput("mpy_latency",  64'(lat), 64'd18);
    checkOutput("mpy_busy_cnt", 64'(busy_cnt), 64'd17);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {63'd0, bus_if.DONE}, 64'd0);
    checkOutput("res_stable",     {32'd0, bus_if.RES}, 64'hFFFE0001);

    applyStimulus(2'b01, 1'b0, 1'b0, 16'hFFFF, 16'h0002, lat, busy_cnt);
    checkOutput("mpys_res",    {32'd0, bus_if.RES}, 64'hFFFFFFFE);
    checkOutput("mpys_sumext", {63'd0, bus_if.SUMEXT}, 64'd1);

    applyStimulus(2'b01, 1'b0, 1'b0, 16'h8000, 16'h8000, lat, busy_cnt);
    checkOutput("mpys_min_res",    {32'd0, bus_if.RES}, 64'h40000000);
    checkOutput("mpys_min_sumext", {63'd0, bus_if.SUMEXT}, 64'd0);
    checkOutput("mpys_min_v",      {63'd0, bus_if.V}, 64'd0);

    applyStimulus(2'b10, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, lat, busy_cnt);
    checkOutput("mac1_res",    {32'd0, bus_if.RES}, 64'hFFFE0001);
    checkOutput("mac1_sumext", {63'd0, bus_if.SUMEXT}, 64'd0);
    applyStimulus(2'b10, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, lat, busy_cnt);
    checkOutput("mac2_res",    {32'd0, bus_if.RES}, 64'hFFFC0002);
    checkOutput("mac2_sumext", {63'd0, bus_if.SUMEXT}, 64'd1);

    @(negedge clk);
    bus_if.CLR_ACC = 1'b1;
    @(negedge clk);
    bus_if.CLR_ACC = 1'b0;
    checkOutput("clr_res",          {32'd0, bus_if.RES}, 64'd0);
    checkOutput("clr_keeps_sumext", {63'd0, bus_if.SUMEXT}, 64'd1);

    applyStimulus(2'b11, 1'b0, 1'b0, 16'h8000, 16'h8000, lat, busy_cnt);
    checkOutput("macs1_res", {32'd0, bus_if.RES}, 64'h40000000);
    checkOutput("macs1_v",   {63'd0, bus_if.V}, 64'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 16'h8000, 16'h8000, lat, busy_cnt);
`ifdef ARIT_MPY_SAT_EN
    checkOutput("macs2_res",    {32'd0, bus_if.RES}, 64'h7FFFFFFF);
    checkOutput("macs2_sumext", {63'd0, bus_if.SUMEXT}, 64'd0);
`else
    checkOutput("macs2_res",    {32'd0, bus_if.RES}, 64'h80000000);
    checkOutput("macs2_sumext", {63'd0, bus_if.SUMEXT}, 64'd1);
`endif
    checkOutput("macs2_v", {63'd0, bus_if.V}, 64'd1);

    @(negedge clk);
    bus_if.CLR_ACC = 1'b1;
    @(negedge clk);
    bus_if.CLR_ACC = 1'b0;
    checkOutput("clr_keeps_v", {63'd0, bus_if.V}, 64'd1);

    applyStimulus(2'b01, 1'b1, 1'b0, 16'h12FF, 16'h5503, lat, busy_cnt);
    checkOutput("byte_res",     {32'd0, bus_if.RES}, 64'hFFFFFFFD);
    checkOutput("byte_latency", 64'(lat), 64'd10);
    checkOutput("byte_sumext",  {63'd0, bus_if.SUMEXT}, 64'd1);
    checkOutput("byte_v",       {63'd0, bus_if.V}, 64'd0);

    @(negedge clk);
    bus_if.MODE  = 2'b00;
    bus_if.BW    = 1'b0;
    bus_if.OP1   = 16'h0003;
    bus_if.OP2   = 16'h0004;
    bus_if.START = 1'b1;
    @(posedge clk);
    #1;
    bus_if.START = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_if.START = 1'b1;
    bus_if.MODE  = 2'b10;
    bus_if.OP1   = 16'hFFFF;
    bus_if.OP2   = 16'hFFFF;
    @(posedge clk);
    #1;
    bus_if.START = 1'b0;
    checkOutput("busy_ignores_start", {63'd0, bus_if.BUSY}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_res",  {32'd0, bus_if.RES}, 64'd0);
    checkOutput("midrst_busy", {63'd0, bus_if.BUSY}, 64'd0);
    checkOutput("midrst_sumext", {63'd0, bus_if.SUMEXT}, 64'd0);
    #1 rst = 1'b0;
    done_cnt = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus_if.DONE) done_cnt++;
    end
    checkOutput("midrst_no_done", 64'(done_cnt), 64'd0);

    applyStimulus(2'b00, 1'b0, 1'b0, 16'h0003, 16'h0004, lat, busy_cnt);
    checkOutput("fresh_res",     {32'd0, bus_if.RES}, 64'h0000000C);
    checkOutput("fresh_latency", 64'(lat), 64'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/arit_mpy.md
Name: arit_mpy

Overview:
- Parametrised multi-cycle multiply / multiply-accumulate unit; the sequential successor to the combinational add/subtract circuit.
- Radix-2 shift-add multiplier with four modes:
  - MPY: unsigned multiply.
  - MPYS: signed multiply.
  - MAC: unsigned multiply-accumulate.
  - MACS: signed multiply-accumulate.
- Supports byte mode (BW) and V/SUMEXT flag generation.
- Sits beside the ALU as a memory-mapped hardware-multiplier peripheral datapath.

Parameters:
- SIZE, 16, operand width in bits; must be >= 8 (byte mode uses the low 8 bits).
- CW, 5, iteration-counter width; must satisfy 2**CW > SIZE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- MODE  input  2  00 MPY, 01 MPYS, 10 MAC, 11 MACS; captured with START.
- BW  input  1  1 = byte operation: OP1[7:0], OP2[7:0] only; captured with START.
- CLR_ACC  input  1  clears RES to 0; acts only in IDLE.
- OP1  input  SIZE  multiplicand; captured with START.
- OP2  input  SIZE  multiplier; captured with START.
- RES  output  2*SIZE  result / accumulator; reset 0.
- SUMEXT  output  1  mode-dependent extension flag; reset 0.
- V  output  1  signed accumulate overflow (MACS only); reset 0.
- BUSY  output  1  operation in progress; reset 0.
- DONE  output  1  one-cycle completion pulse; reset 0.

Behaviour:
- States: IDLE, MUL, ACC. Reset forces IDLE and all outputs/registers to 0.
- IDLE + START=1:
  - Capture MODE and BW.
  - Operand width N = 8 if BW, else SIZE. Operands are sign-extended (signed modes) or zero-extended from bit N-1.
  - Signed modes: latch magnitudes and neg = sign(a) XOR sign(b).
  - Clear the 2*SIZE partial product; load counter = N; go to MUL; BUSY=1.
- MUL: one shift-add step per cycle; counter decrements; when counter reaches 1, go to ACC.
- ACC:
  - Form product P = neg ? -mag : mag, 2*SIZE-bit two's complement.
  - MPY/MPYS: RES <= P.
  - MAC/MACS: RES <= RES + P, modulo 2^(2*SIZE).
  - Next cycle: IDLE, BUSY=0, DONE=1 for exactly one cycle.
- Latency: DONE and the final RES rise N+2 clock edges after the edge that samples START; RES is stable from DONE onward.
- SUMEXT, updated in ACC only:
  - MPY: 0.
  - MPYS: RES MSB.
  - MAC: carry out of the 2*SIZE addition.
  - MACS: MSB of the new RES.
- V, updated in ACC only:
  - MACS: 1 when both addends have the same sign and the sum sign differs.
  - All other modes: 0.
- Boundary cases:
  - START while BUSY is ignored; no queueing.
  - CLR_ACC and START in the same IDLE cycle: RES cleared first, so MAC accumulates onto 0.
  - CLR_ACC while BUSY is ignored. CLR_ACC does not alter SUMEXT or V.
  - Operand or MODE changes during BUSY have no effect.
  - rst mid-operation: immediate IDLE, RES/flags 0, no DONE pulse.
  - Signed MIN x MIN (e.g. 0x8000*0x8000) yields a positive 2*SIZE result with no overflow.

Optional Feature:
- Macro: ARIT_MPY_SAT_EN.
- Defined: in MACS, when V would be 1, RES saturates instead of wrapping:
  - to 0x7FFF...F if P is positive;
  - to 0x8000...0 if P is negative.
  - V is still reported as 1.
- Undefined: wrap-around accumulation; no saturation logic synthesised.

Decomposition:
- Shared package arit_pkg holds:
  - MODE encodings: MODE_MPY, MODE_MPYS, MODE_MAC, MODE_MACS.
  - State encoding: ST_IDLE, ST_MUL, ST_ACC.
  - Byte width constant BYTE_W = 8.
- One natural sub-module: arit_mpy_step, a combinational single shift-add iteration (partial product, multiplicand, multiplier bit in; next partial product out), instantiated once.
- Control FSM, sign handling and accumulation stay in arit_mpy.

Test Plan (SIZE=16):
- MPY, OP1=0xFFFF, OP2=0xFFFF -> RES=0xFFFE0001, SUMEXT=0, V=0, DONE 18 edges after START; BUSY high for 17 cycles before DONE.
- MPYS, OP1=0xFFFF, OP2=0x0002 -> RES=0xFFFFFFFE, SUMEXT=1; MPYS 0x8000*0x8000 -> RES=0x40000000, SUMEXT=0.
- CLR_ACC, then MAC 0xFFFF*0xFFFF twice -> RES=0xFFFE0001 then RES=0xFFFC0002 with SUMEXT=1.
- CLR_ACC, then MACS 0x8000*0x8000 twice -> RES=0x80000000, V=1; with ARIT_MPY_SAT_EN -> RES=0x7FFFFFFF, V=1.
- MPYS with BW=1, OP1=0x12FF, OP2=0x5503 -> RES=0xFFFFFFFD (-1*3), DONE 10 edges after START.
- START MPY 0x0003*0x0004, pulse START again and pulse rst during MUL -> second START ignored; after rst BUSY=0, RES=0, no DONE; a fresh START gives RES=0x0000000C.
